// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared types, rate constants, lane ordering and FSM encoding
//                for the Keccak squeeze-phase reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int LANE_W        = 64;
    localparam int RATE_SHA3_256 = 17;
    localparam int RATE_SHAKE128 = 21;

    // Full 5x5 lane state, indexed [x][y]
    typedef logic [4:0][4:0][LANE_W-1:0] state_t;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_xy_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        PERM = 2'd2
    } sq_state_e;

    // Sponge lane number n = x + 5*y mapped back to its (x, y) coordinates
    function automatic lane_xy_t lane_index(input int n);
        lane_xy_t r;
        r.x = 3'(n % 5);
        r.y = 3'(n / 5);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_state_byte_sel.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_state_byte_sel
//  Description : Combinational selector returning rate byte idx_i of the
//                state, lanes in sponge order, bytes LSB-first within a lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_state_byte_sel
    import keccak_pkg::*;
#(
    parameter int W          = 64,
    parameter int RATE_LANES = 17,
    parameter int IDX_W      = 8
) (
    input  logic [4:0][4:0][W-1:0] state_i,
    input  logic [IDX_W-1:0]       idx_i,
    output logic [7:0]             byte_o
);

    localparam int BPL = W / 8;
    localparam int RB  = RATE_LANES * BPL;

    // Rate portion flattened into a byte array in output order
    logic [RB-1:0][7:0] w_rate_bytes;
    // Capacity lanes never leave this block; fold them away explicitly
    logic               w_unused_state;

    assign w_unused_state = ^state_i;

    generate
        for (genvar n = 0; n < RATE_LANES; n++) begin : g_lane
            localparam lane_xy_t XY = lane_index(n);
            for (genvar k = 0; k < BPL; k++) begin : g_byte
                assign w_rate_bytes[n*BPL + k] = state_i[XY.x][XY.y][8*k +: 8];
            end
        end
    endgenerate

    // Byte mux; out-of-range indices read as zero
    always_comb begin
        byte_o = 8'h00;
        if (idx_i < IDX_W'(RB)) begin
            byte_o = w_rate_bytes[idx_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/keccak_squeeze.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_squeeze
//  Description : Keccak sponge squeeze reader. Streams rate bytes of a held
//                state over valid/ready and requests further permutations
//                when more bytes than one rate block are required.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int W          = 64,
    parameter int RATE_LANES = RATE_SHA3_256,
    parameter int LEN_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       out_len_i,
    input  logic [4:0][4:0][W-1:0] state_i,
    output logic                   perm_start_o,
    output logic [4:0][4:0][W-1:0] perm_state_o,
    input  logic                   perm_done_i,
    input  logic [4:0][4:0][W-1:0] perm_state_i,
    output logic [7:0]             out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_last_o,
    output logic                   busy_o
);

    localparam int RB    = RATE_LANES * (W / 8);
    // One extra bit of headroom so RB itself is representable
    localparam int IDX_W = $clog2(RB + 1);

    sq_state_e              state_q, state_d;
    logic [4:0][4:0][W-1:0] held_q, held_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    // High only for the first cycle spent in PERM
    logic                   perm_first_q, perm_first_d;

    keccak_state_byte_sel #(
        .W          (W),
        .RATE_LANES (RATE_LANES),
        .IDX_W      (IDX_W)
    ) u_byte_sel (
        .state_i (held_q),
        .idx_i   (idx_q),
        .byte_o  (out_data_o)
    );

    assign out_valid_o  = (state_q == EMIT);
    assign out_last_o   = out_valid_o & (rem_q == LEN_W'(1));
    assign busy_o       = (state_q != IDLE);
    assign perm_start_o = (state_q == PERM) & perm_first_q;
    assign perm_state_o = held_q;

    // State register, counters and held Keccak state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            held_q       <= '0;
            idx_q        <= '0;
            rem_q        <= '0;
            perm_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            perm_first_q <= perm_first_d;
        end
    end

    // Next-state logic: capture, byte stepping, block turnover
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        perm_first_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && (out_len_i != '0)) begin
                    held_d  = state_i;
                    rem_d   = out_len_i;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready_i) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end else if (idx_q == IDX_W'(RB - 1)) begin
                        idx_d        = '0;
                        perm_first_d = 1'b1;
                        state_d      = PERM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PERM: begin
                // A done pulse coincident with the request is accepted
                if (perm_done_i) begin
                    held_d  = perm_state_i;
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_squeeze.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keccak_squeeze
//  Description : Self-checking bench for keccak_squeeze using an expected
//                byte scoreboard (w = 64, RATE_LANES = 17, RB = 136).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_squeeze;
    import keccak_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] out_len_i;
    state_t      state_i;
    logic        perm_start_o;
    state_t      perm_state_o;
    logic        perm_done_i;
    state_t      perm_state_i;
    logic [7:0]  out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];   // {last, data}
    state_t      st_ramp;
    state_t      st_a5;

    keccak_squeeze #(.W(64), .RATE_LANES(17), .LEN_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .out_len_i    (out_len_i),
        .state_i      (state_i),
        .perm_start_o (perm_start_o),
        .perm_state_o (perm_state_o),
        .perm_done_i  (perm_done_i),
        .perm_state_i (perm_state_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_range(input int first, input int count, input logic [7:0] fixed,
                              input bit use_fixed, input bit last_at_end);
        for (int i = 0; i < count; i++) begin
            logic [7:0] d;
            d = use_fixed ? fixed : 8'(first + i);
            exp_q.push_back({(last_at_end && (i == count - 1)), d});
        end
    endtask

    // Pulse start_i for one cycle; returns #1 into the cycle after capture
    task automatic do_start(input int len);
        out_len_i = 16'(len);
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        out_len_i = 16'hBEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy_o, out_valid_o, out_last_o, perm_start_o, out_data_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b last=%b pstart=%b data=%h, want all 0",
                     busy_o, out_valid_o, out_last_o, perm_start_o, out_data_o);
        end
        checks++;
        if (perm_state_o !== '0) begin
            errors++;
            $display("FAIL reset_held_state: got nonzero perm_state_o, want 0");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream32();
        int pst = 0;
        push_range(0, 32, 8'h00, 1'b0, 1'b1);
        out_ready_i = 1'b1;
        do_start(32);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (perm_start_o) pst++;
            checks++;
            if (!out_valid_o || {out_last_o, out_data_o} !== exp_q[0]) begin
                errors++;
                $display("FAIL stream32 cycle %0d: got valid=%b last=%b data=%h, want valid=1 last=%b data=%h",
                         i + 1, out_valid_o, out_last_o, out_data_o, exp_q[0][8], exp_q[0][7:0]);
            end
            void'(exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || out_last_o !== 1'b0 || pst != 0) begin
            errors++;
            $display("FAIL stream32_end: got busy=%b valid=%b last=%b pstarts=%0d, want 0 0 0 0",
                     busy_o, out_valid_o, out_last_o, pst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        push_range(0, 8, 8'h00, 1'b0, 1'b1);
        out_ready_i = 1'b0;
        do_start(8);
        for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            if (out_valid_o) begin
                checks++;
                if ({out_last_o, out_data_o} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL backpressure cycle %0d: got last=%b data=%h, want last=%b data=%h",
                             cyc, out_last_o, out_data_o, exp_q[0][8], exp_q[0][7:0]);
                end
                if (out_ready_i) void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            out_ready_i = ~out_ready_i;
        end
        checks++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_end: got remaining=%0d busy=%b, want 0 0", exp_q.size(), busy_o);
            exp_q.delete();
        end
        out_ready_i = 1'b1;
    endtask

    task automatic test_perm140();
        int pst = 0;
        int cd  = -1;
        push_range(0, 136, 8'h00, 1'b0, 1'b0);
        push_range(0, 4, 8'hA5, 1'b1, 1'b1);
        out_ready_i = 1'b1;
        do_start(140);
        for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            if (perm_start_o) begin
                pst++;
                cd = 3;
                checks++;
                if (perm_state_o !== st_ramp || out_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL perm140_request: got valid=%b state_match=%b, want valid=0 state_match=1",
                             out_valid_o, (perm_state_o === st_ramp));
                end
            end
            if (out_valid_o) begin
                checks++;
                if ({out_last_o, out_data_o} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL perm140 byte %0d: got last=%b data=%h, want last=%b data=%h",
                             140 - exp_q.size(), out_last_o, out_data_o, exp_q[0][8], exp_q[0][7:0]);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            perm_done_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) perm_done_i = 1'b1;
            end
        end
        perm_done_i = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || pst != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL perm140_end: got remaining=%0d pstarts=%0d busy=%b, want 0 1 0",
                     exp_q.size(), pst, busy_o);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_exact136();
        int pst = 0;
        push_range(0, 136, 8'h00, 1'b0, 1'b1);
        out_ready_i = 1'b1;
        do_start(136);
        for (int i = 0; i < 136; i++) begin
            @(negedge clk);
            if (perm_start_o) pst++;
            checks++;
            if (!out_valid_o || {out_last_o, out_data_o} !== exp_q[0]) begin
                errors++;
                $display("FAIL exact136 byte %0d: got valid=%b last=%b data=%h, want valid=1 last=%b data=%h",
                         i, out_valid_o, out_last_o, out_data_o, exp_q[0][8], exp_q[0][7:0]);
            end
            void'(exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        repeat (4) begin
            @(negedge clk);
            if (perm_start_o) pst++;
        end
        checks++;
        if (pst != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL exact136_end: got pstarts=%0d busy=%b, want 0 0", pst, busy_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal_start();
        out_ready_i = 1'b1;
        do_start(0);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_start: got busy=%b valid=%b, want 0 0", busy_o, out_valid_o);
        end
        @(posedge clk);
        #1;
        push_range(0, 16, 8'h00, 1'b0, 1'b1);
        do_start(16);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (!out_valid_o || {out_last_o, out_data_o} !== exp_q[0]) begin
                errors++;
                $display("FAIL restart_ignored byte %0d: got valid=%b last=%b data=%h, want valid=1 last=%b data=%h",
                         i, out_valid_o, out_last_o, out_data_o, exp_q[0][8], exp_q[0][7:0]);
            end
            void'(exp_q.pop_front());
            @(posedge clk);
            #1;
            start_i   = (i == 4);
            out_len_i = 16'd3;
        end
        start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored_end: got busy=%b, want 0", busy_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        bit hit = 1'b0;
        out_ready_i = 1'b1;
        do_start(32);
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            @(negedge clk);
            if (out_valid_o && out_data_o == 8'h0A) begin
                hit   = 1'b1;
                rst_n = 1'b0;
                #1;
                checks++;
                if ({busy_o, out_valid_o, out_last_o, perm_start_o, out_data_o} !== 12'h000) begin
                    errors++;
                    $display("FAIL midstream_reset: got busy=%b valid=%b last=%b pstart=%b data=%h, want all 0",
                             busy_o, out_valid_o, out_last_o, perm_start_o, out_data_o);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midstream_reset_reach: got byte 0A never valid, want it valid");
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_range(0, 2, 8'h00, 1'b0, 1'b1);
        do_start(2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (!out_valid_o || {out_last_o, out_data_o} !== exp_q[0]) begin
                errors++;
                $display("FAIL after_reset byte %0d: got valid=%b last=%b data=%h, want valid=1 last=%b data=%h",
                         i, out_valid_o, out_last_o, out_data_o, exp_q[0][8], exp_q[0][7:0]);
            end
            void'(exp_q.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int n = 0; n < 25; n++) begin
            st_ramp[n % 5][n / 5] = 64'h0706050403020100 + 64'(n) * 64'h0808080808080808;
            st_a5[n % 5][n / 5]   = 64'hA5A5A5A5A5A5A5A5;
        end
        state_i      = st_ramp;
        perm_state_i = st_a5;
        start_i      = 1'b0;
        out_len_i    = '0;
        perm_done_i  = 1'b0;
        out_ready_i  = 1'b1;
        rst_n        = 1'b1;

        test_reset();
        test_stream32();
        test_backpressure();
        test_perm140();
        test_exact136();
        test_illegal_start();
        test_reset_midstream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
